// File: rtl/adc_nibble2word.sv
`default_nettype none
// ============================================================================
// Module      : adc_nibble2word
// Description : Reassembles MSB-first ADC nibble slices into full samples for
//               all ports in parallel, with frame lock tracking.
// Revision    : 1.0 - initial release
// ============================================================================

module adc_nibble2word #(
    parameter  int PORTS            = 8,
    parameter  int NIBBLE_WIDTH     = 4,
    parameter  int NIBBLES_PER_WORD = 3,
    localparam int WORD_WIDTH       = NIBBLE_WIDTH * NIBBLES_PER_WORD
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 nib_valid,
    input  logic                                 frame,
    input  logic [PORTS-1:0][NIBBLE_WIDTH-1:0]   nib_in,
    output logic [PORTS-1:0][WORD_WIDTH-1:0]     data_out,
    output logic                                 data_valid,
    output logic                                 locked,
    output logic                                 sync_err
);

    localparam int c_SHIFT_W = WORD_WIDTH - NIBBLE_WIDTH;
    localparam int c_CNT_W   = $clog2(NIBBLES_PER_WORD);

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(NIBBLES_PER_WORD - 1);

    localparam logic [0:0] c_ST_HUNT   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    logic w_load;   // first slice of a word: restart the shift registers
    logic w_shift;  // middle slice
    logic w_final;  // last slice: publish the word
    logic w_err;

    logic [c_SHIFT_W-1:0]                r_shreg [PORTS];
    logic [PORTS-1:0][WORD_WIDTH-1:0]    r_data;
    logic                                r_data_valid;
    logic                                r_locked;
    logic                                r_sync_err;

    // ------------------------------------------------------------------------
    // Framing state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_HUNT;
            r_cnt   <= c_CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_final     = 1'b0;
        w_err       = 1'b0;

        if (nib_valid) begin
            case (r_state)
                c_ST_HUNT: begin
                    if (frame) begin
                        w_load      = 1'b1;
                        w_cnt_nxt   = c_CNT_ONE;
                        w_state_nxt = c_ST_LOCKED;
                    end
                end
                default: begin
                    if (frame) begin
                        // An early frame restarts the word; lock is kept.
                        w_load    = 1'b1;
                        w_cnt_nxt = c_CNT_ONE;
                        w_err     = (r_cnt != c_CNT_ZERO);
                    end else if (r_cnt == c_CNT_ZERO) begin
                        w_err       = 1'b1;
                        w_cnt_nxt   = c_CNT_ZERO;
                        w_state_nxt = c_ST_HUNT;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_final   = 1'b1;
                        w_cnt_nxt = c_CNT_ZERO;
                    end else begin
                        w_shift   = 1'b1;
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Per-port shift registers and output word registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PORTS; p++) begin
                r_shreg[p] <= '0;
            end
            r_data <= '0;
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (w_load) begin
                    r_shreg[p] <= c_SHIFT_W'(nib_in[p]);
                end else if (w_shift) begin
                    r_shreg[p] <= (r_shreg[p] << NIBBLE_WIDTH) | c_SHIFT_W'(nib_in[p]);
                end
                if (w_final) begin
                    r_data[p] <= {r_shreg[p], nib_in[p]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_data_valid <= w_final;
            r_locked     <= (w_state_nxt == c_ST_LOCKED);
            r_sync_err   <= w_err;
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_data_valid;
    assign locked     = r_locked;
    assign sync_err   = r_sync_err;

endmodule

`default_nettype wire

// File: tb/tb_adc_nibble2word.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_nibble2word
// Description : Table-driven self-checking bench with a word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_adc_nibble2word;

    localparam int PORTS = 8;
    localparam int NW    = 4;
    localparam int NPW   = 3;
    localparam int WW    = NW * NPW;

    logic                         clk;
    logic                         rst;
    logic                         nib_valid;
    logic                         frame;
    logic [PORTS-1:0][NW-1:0]     nib_in;
    logic [PORTS-1:0][WW-1:0]     data_out;
    logic                         data_valid;
    logic                         locked;
    logic                         sync_err;

    int checks   = 0;
    int failures = 0;

    adc_nibble2word #(
        .PORTS            (PORTS),
        .NIBBLE_WIDTH     (NW),
        .NIBBLES_PER_WORD (NPW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .nib_valid  (nib_valid),
        .frame      (frame),
        .nib_in     (nib_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        nv;
        logic        fr;
        logic [3:0]  n0;   // slice for ports 0..PORTS-2 (xor'd with port index)
        logic [3:0]  n7;   // slice for the last port
        logic        ev;
        logic        el;
        logic        ee;
        logic [11:0] w0;
        logic [11:0] w7;
    } vec_t;

    vec_t vecs[$];
    logic [PORTS*WW-1:0] sb_q[$];

    function automatic vec_t mk(logic r, logic nv, logic fr, logic [3:0] n0, logic [3:0] n7,
                                logic ev, logic el, logic ee, logic [11:0] w0, logic [11:0] w7);
        vec_t v;
        v.rst = r; v.nv = nv; v.fr = fr; v.n0 = n0; v.n7 = n7;
        v.ev = ev; v.el = el; v.ee = ee; v.w0 = w0; v.w7 = w7;
        return v;
    endfunction

    function automatic logic [PORTS-1:0][NW-1:0] nibs_of(logic [3:0] n0, logic [3:0] n7);
        logic [PORTS-1:0][NW-1:0] r;
        for (int p = 0; p < PORTS - 1; p++) r[p] = n0 ^ 4'(p);
        r[PORTS-1] = n7;
        return r;
    endfunction

    function automatic logic [PORTS-1:0][WW-1:0] word_of(logic [11:0] w0, logic [11:0] w7);
        logic [PORTS-1:0][WW-1:0] r;
        logic [3:0] pn;
        for (int p = 0; p < PORTS - 1; p++) begin
            pn   = 4'(p);
            r[p] = w0 ^ {NPW{pn}};
        end
        r[PORTS-1] = w7;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [PORTS*WW-1:0] got,
                       input logic [PORTS*WW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%h exp=%h", name, idx, got, exp);
        end
    endtask

    // Scoreboard: every data_valid must match the next queued word.
    always @(posedge clk) begin
        #1;
        chk("valid_and_err_exclusive", -1, PORTS*WW'(data_valid & sync_err), '0);
        if (data_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", -1, PORTS*WW'(1), '0);
            end else begin
                chk("sb_word", -1, data_out, sb_q.pop_front());
            end
        end
    end

    logic [PORTS-1:0][WW-1:0] hold_w;

    initial begin
        rst       = 1'b1;
        nib_valid = 1'b0;
        frame     = 1'b0;
        nib_in    = '0;
        hold_w    = '0;

        // basic assembly
        vecs.push_back(mk(0,1,1,4'hA,4'h8, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'hB,4'h0, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'hC,4'h1, 1,1,0, 12'hABC,12'h801));
        // gapped word, junk frame during gaps
        vecs.push_back(mk(0,1,1,4'hD,4'h7, 0,1,0, 12'h000,12'h000));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,1,4'h0,4'h0, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'hE,4'hF, 0,1,0, 12'h000,12'h000));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0,0,1,4'h0,4'h0, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'hF,4'hE, 1,1,0, 12'hDEF,12'h7FE));
        vecs.push_back(mk(0,0,0,4'h0,4'h0, 0,1,0, 12'h000,12'h000));
        // early frame
        vecs.push_back(mk(0,1,1,4'hF,4'hF, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'hE,4'hE, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,1,4'h4,4'h4, 0,1,1, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'h5,4'h5, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'h6,4'h6, 1,1,0, 12'h456,12'h456));
        // missing frame
        vecs.push_back(mk(0,1,1,4'h3,4'h3, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'h2,4'h2, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'h1,4'h1, 1,1,0, 12'h321,12'h321));
        vecs.push_back(mk(0,1,0,4'h7,4'h7, 0,0,1, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'h8,4'h8, 0,0,0, 12'h000,12'h000));
        // hunt discard
        vecs.push_back(mk(0,1,0,4'h5,4'h5, 0,0,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'h6,4'h6, 0,0,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,1,4'h1,4'h1, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'h2,4'h2, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'h3,4'h3, 1,1,0, 12'h123,12'h123));
        // reset mid-word
        vecs.push_back(mk(0,1,1,4'h9,4'h9, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'h9,4'h9, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(1,1,0,4'h9,4'h9, 0,0,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'h9,4'h9, 0,0,0, 12'h000,12'h000));
        // back-to-back words at full rate
        vecs.push_back(mk(0,1,1,4'hA,4'hA, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'hB,4'hB, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'hC,4'hC, 1,1,0, 12'hABC,12'hABC));
        vecs.push_back(mk(0,1,1,4'h1,4'hF, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'h2,4'hE, 0,1,0, 12'h000,12'h000));
        vecs.push_back(mk(0,1,0,4'h3,4'hD, 1,1,0, 12'h123,12'hFED));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_data_out",   -1, data_out, '0);
        chk("reset_data_valid", -1, PORTS*WW'(data_valid), '0);
        chk("reset_locked",     -1, PORTS*WW'(locked), '0);
        chk("reset_sync_err",   -1, PORTS*WW'(sync_err), '0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            nib_valid = vecs[i].nv;
            frame     = vecs[i].fr;
            nib_in    = nibs_of(vecs[i].n0, vecs[i].n7);
            if (vecs[i].ev && !vecs[i].rst) sb_q.push_back(word_of(vecs[i].w0, vecs[i].w7));
            @(posedge clk);
            #1;
            if (vecs[i].rst)     hold_w = '0;
            else if (vecs[i].ev) hold_w = word_of(vecs[i].w0, vecs[i].w7);
            chk("data_valid", i, PORTS*WW'(data_valid), PORTS*WW'(vecs[i].ev));
            chk("locked",     i, PORTS*WW'(locked),     PORTS*WW'(vecs[i].el));
            chk("sync_err",   i, PORTS*WW'(sync_err),   PORTS*WW'(vecs[i].ee));
            chk("data_out",   i, data_out, hold_w);
        end

        @(negedge clk);
        rst       = 1'b0;
        nib_valid = 1'b0;
        frame     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", -1, PORTS*WW'(sb_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
